// File: rtl/pc_next_unit.sv
// MIPS fetch-stage PC register with prioritised next-PC selection.
// Redirects that arrive while fetch is stalled are held until release.
module pc_next_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                INC          = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int                ALIGN_BITS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exc,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_dst,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_dst,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_dst,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_seq,
    output logic              redirect_taken,
    output logic              pend_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);
    // All-zero mask when ALIGN_BITS is 0, which disables the check.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_exc_q, pend_exc_d;
    logic              pend_valid_q, pend_valid_d;
    logic              redir_taken_q, redir_taken_d;
    logic              addr_err_q, addr_err_d;

    logic              redir;
    logic [ADDR_W-1:0] tgt;

    assign pc_seq = pc_q + INC_W;
    assign redir  = exc | jr | jump | branch;

    always_comb begin
        if (exc)         tgt = EXC_VECTOR;
        else if (jr)     tgt = jr_dst;
        else if (jump)   tgt = jump_dst;
        else             tgt = branch_dst;
    end

    always_comb begin
        pc_d          = pc_q;
        pend_addr_d   = pend_addr_q;
        pend_exc_d    = pend_exc_q;
        pend_valid_d  = pend_valid_q;
        redir_taken_d = 1'b0;
        addr_err_d    = 1'b0;
        if (stall) begin
            // A held exception may only be replaced by another exception.
            if (redir && (!pend_valid_q || !pend_exc_q || exc)) begin
                pend_addr_d  = tgt;
                pend_exc_d   = exc;
                pend_valid_d = 1'b1;
            end
        end else begin
            pend_valid_d = 1'b0;
            pend_exc_d   = 1'b0;
            if (pend_valid_q && pend_exc_q) begin
                pc_d          = pend_addr_q;
                redir_taken_d = 1'b1;
                addr_err_d    = |(pend_addr_q & ALIGN_MASK);
            end else if (redir) begin
                pc_d          = tgt;
                redir_taken_d = 1'b1;
                addr_err_d    = |(tgt & ALIGN_MASK);
            end else if (pend_valid_q) begin
                pc_d          = pend_addr_q;
                redir_taken_d = 1'b1;
                addr_err_d    = |(pend_addr_q & ALIGN_MASK);
            end else begin
                pc_d = pc_seq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pend_addr_q   <= '0;
            pend_exc_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            redir_taken_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_addr_q   <= pend_addr_d;
            pend_exc_q    <= pend_exc_d;
            pend_valid_q  <= pend_valid_d;
            redir_taken_q <= redir_taken_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc             = pc_q;
    assign redirect_taken = redir_taken_q;
    assign pend_valid     = pend_valid_q;
    assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed and randomised checks of pc_next_unit against a cycle-level
// behavioural model of the fetch PC and its held-redirect slot.
module tb_pc_next_unit;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic        clk, rst_n, stall, exc, jr, jump, branch;
    logic [31:0] jr_dst, jump_dst, branch_dst;
    logic [31:0] pc, pc_seq;
    logic        redirect_taken, pend_valid, addr_err;

    int tests = 0;
    int fails = 0;

    // model state
    logic [31:0] m_pc;
    bit          m_rt, m_ae;
    bit          h_valid, h_exc;
    logic [31:0] h_addr;

    pc_next_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc),
        .jr(jr), .jr_dst(jr_dst), .jump(jump), .jump_dst(jump_dst),
        .branch(branch), .branch_dst(branch_dst),
        .pc(pc), .pc_seq(pc_seq), .redirect_taken(redirect_taken),
        .pend_valid(pend_valid), .addr_err(addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_seq"}, pc_seq, m_pc + 32'd4);
        chk({tag, ".redirect_taken"}, {31'd0, redirect_taken}, {31'd0, m_rt});
        chk({tag, ".pend_valid"}, {31'd0, pend_valid}, {31'd0, h_valid});
        chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_ae});
    endtask

    task automatic model_reset();
        m_pc = RV; m_rt = 0; m_ae = 0;
        h_valid = 0; h_exc = 0; h_addr = '0;
    endtask

    // One clock of the architectural rules, from the inputs present at the edge.
    task automatic model_step();
        bit          any_req;
        logic [31:0] target, applied;
        bit          use_applied;
        any_req = exc || jr || jump || branch;
        target  = exc ? EV : jr ? jr_dst : jump ? jump_dst : branch_dst;
        m_rt = 0; m_ae = 0;
        if (stall) begin
            if (any_req && !(h_valid && h_exc && !exc)) begin
                h_valid = 1; h_exc = exc; h_addr = target;
            end
        end else begin
            use_applied = 1;
            if (h_valid && h_exc)  applied = h_addr;
            else if (any_req)      applied = target;
            else if (h_valid)      applied = h_addr;
            else begin
                applied = m_pc + 32'd4;
                use_applied = 0;
            end
            m_pc = applied;
            m_rt = use_applied;
            m_ae = use_applied && (applied % 4 != 0);
            h_valid = 0; h_exc = 0;
        end
    endtask

    task automatic step(input string tag, input bit s, input bit e,
                        input bit r, input logic [31:0] rd,
                        input bit j, input logic [31:0] jd,
                        input bit b, input logic [31:0] bd);
        stall = s; exc = e; jr = r; jr_dst = rd;
        jump = j; jump_dst = jd; branch = b; branch_dst = bd;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] t1, t2, t3;
        rst_n = 1'b0;
        stall = 0; exc = 0; jr = 0; jump = 0; branch = 0;
        jr_dst = '0; jump_dst = '0; branch_dst = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_pc_const", pc, 32'hBFC0_0000);
        rst_n = 1'b1;

        idle("seq1");
        idle("seq2");
        idle("seq3");
        chk("seq3_const", pc, 32'hBFC0_000C);

        step("prio_jr", 0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h100);
        chk("prio_jr_const", pc, 32'h300);
        step("prio_exc", 0, 1, 1, 32'h300, 1, 32'h200, 1, 32'h100);
        chk("prio_exc_const", pc, 32'h8000_0180);

        step("stall_b1", 1, 0, 0, 0, 0, 0, 1, 32'h400);
        step("stall_b2", 1, 0, 0, 0, 0, 0, 0, 0);
        step("stall_b3", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_hold_const", pc, 32'h8000_0180);
        idle("stall_rel");
        chk("stall_rel_const", pc, 32'h400);
        idle("stall_after");

        step("exc_first1", 1, 1, 0, 0, 0, 0, 0, 0);
        step("exc_first2", 1, 0, 0, 0, 1, 32'h500, 0, 0);
        idle("exc_first_rel");
        chk("exc_first_const", pc, 32'h8000_0180);
        step("jmp_first1", 1, 0, 0, 0, 1, 32'h500, 0, 0);
        step("jmp_first2", 1, 1, 0, 0, 0, 0, 0, 0);
        idle("jmp_first_rel");
        chk("jmp_first_const", pc, 32'h8000_0180);

        step("misalign", 0, 0, 1, 32'h1002, 0, 0, 0, 0);
        chk("misalign_err_const", {31'd0, addr_err}, 32'd1);
        idle("misalign_clear");
        step("to_top", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle("wrap");
        chk("wrap_const", pc, 32'h0);

        step("rst_stall", 1, 0, 0, 0, 0, 0, 1, 32'h700);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1 rst_n = 1'b1;
        step("post_rst_stall", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("post_rst_rel");
        chk("post_rst_const", pc, 32'hBFC0_0004);

        for (int i = 0; i < 400; i++) begin
            t1 = $urandom; t2 = $urandom; t3 = $urandom;
            if ($urandom_range(3) != 0) t1[1:0] = 2'b00;
            if ($urandom_range(3) != 0) t2[1:0] = 2'b00;
            if ($urandom_range(3) != 0) t3[1:0] = 2'b00;
            step($sformatf("rand%0d", i), ($urandom_range(2) == 0),
                 ($urandom_range(9) == 0),
                 ($urandom_range(5) == 0), t1,
                 ($urandom_range(5) == 0), t2,
                 ($urandom_range(4) == 0), t3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
